// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one fixed-latency memory bus between NUM_CH requesters
//            (ch0 = instruction fetch, ch1 = data, further channels for
//            DMA/debug). Round-robin or fixed-priority arbitration. Each access
//            runs IDLE -> ACCESS (MEM_LATENCY cycles) -> DONE (1 cycle).
// Ports    : clk, reset        clock (rising edge), synchronous active-high reset
//            req/we            per-channel request level and write enable
//            addr/wdata        flattened per-channel operands, ch k at [k*W +: W]
//            gnt/done          one-hot grant / completion pulses
//            rdata             captured read data, valid while done is high
//            mem_readM/
//            mem_writeM        memory strobes, held for the whole ACCESS phase
//            mem_address/
//            mem_wdata         latched operands driven to memory
//            mem_rdata         memory read data, valid in the last ACCESS cycle
//            busy              high in ACCESS and DONE
//            access_count      completed-access counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_CH      = 2,
  parameter int MEM_LATENCY = 2,
  parameter int RR_MODE     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           req,
  input  logic [NUM_CH-1:0]           we,
  input  logic [NUM_CH*WORD_SIZE-1:0] addr,
  input  logic [NUM_CH*WORD_SIZE-1:0] wdata,
  output logic [NUM_CH-1:0]           gnt,
  output logic [NUM_CH-1:0]           done,
  output logic [WORD_SIZE-1:0]        rdata,
  output logic                        mem_readM,
  output logic                        mem_writeM,
  output logic [WORD_SIZE-1:0]        mem_address,
  output logic [WORD_SIZE-1:0]        mem_wdata,
  input  logic [WORD_SIZE-1:0]        mem_rdata,
  output logic                        busy,
  output logic [WORD_SIZE-1:0]        access_count
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CH_W-1:0]  LAST_INIT = CH_W'(NUM_CH - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CH_W-1:0]      r_ch;
  logic                 r_we;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [CH_W-1:0]      r_last;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [WORD_SIZE-1:0] r_count;

  logic                 w_any;
  logic [CH_W-1:0]      w_win;
  logic [CH_W-1:0]      w_lo;
  logic                 w_hi_v;
  logic [CH_W-1:0]      w_hi;

  // --------------------------------------------------------------------------
  // Arbitration. Round-robin is split into two searches: the lowest requesting
  // index strictly above the last winner, falling back to the lowest
  // requesting index overall (the wrap-around case). The descending scan
  // leaves the lowest matching index in each result.
  // --------------------------------------------------------------------------
  always_comb begin
    w_any  = |req;
    w_lo   = '0;
    w_hi   = '0;
    w_hi_v = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo = CH_W'(i);
        if (i > int'(r_last)) begin
          w_hi   = CH_W'(i);
          w_hi_v = 1'b1;
        end
      end
    end
    if ((RR_MODE != 0) && w_hi_v) begin
      w_win = w_hi;
    end else begin
      w_win = w_lo;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. DONE never arbitrates, so an access costs
  // MEM_LATENCY+2 cycles including the IDLE arbitration cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next_state = ST_ACCESS;
      ST_ACCESS: if (r_cnt == CNT_LAST) w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand latch at grant, access cycle counter, read capture and
  // completion counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_ch    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_last  <= LAST_INIT;
      r_rdata <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_ch    <= w_win;
            r_we    <= we[w_win];
            r_addr  <= addr[int'(w_win)*WORD_SIZE +: WORD_SIZE];
            r_wdata <= wdata[int'(w_win)*WORD_SIZE +: WORD_SIZE];
            if (RR_MODE != 0) begin
              r_last <= w_win;
            end
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            if (!r_we) begin
              r_rdata <= mem_rdata;
            end
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. gnt is tied to the first ACCESS cycle (counter still zero).
  // --------------------------------------------------------------------------
  always_comb begin
    gnt        = '0;
    done       = '0;
    mem_readM  = 1'b0;
    mem_writeM = 1'b0;
    busy       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i]  = (r_state == ST_ACCESS) && (r_cnt == '0) && (r_ch == CH_W'(i));
      done[i] = (r_state == ST_DONE) && (r_ch == CH_W'(i));
    end
    if (r_state == ST_ACCESS) begin
      mem_readM  = !r_we;
      mem_writeM = r_we;
    end
    busy = (r_state == ST_ACCESS) || (r_state == ST_DONE);
  end

  assign mem_address  = r_addr;
  assign mem_wdata    = r_wdata;
  assign rdata        = r_rdata;
  assign access_count = r_count;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised shared-memory access unit for the multi-cycle CPU family.
- Arbitrates NUM_CH requesters (channel 0 = instruction fetch, channel 1 = data; more for DMA/debug) onto a single memory bus with fixed multi-cycle latency.
- Lets the split i_/d_ memory interfaces collapse onto one unified memory.
- Sits between the datapath and memory. Bidirectional-bus tristating is done outside this block.

Parameters:
- WORD_SIZE, 16, data and address width.
- NUM_CH, 2, number of requesters (2..8).
- MEM_LATENCY, 2, cycles the memory strobe and address are held per access (>=1).
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_CH  per-channel request level.
- we  input  NUM_CH  per-channel write enable (0 = read), qualified by req.
- addr  input  NUM_CH*WORD_SIZE  flattened addresses, channel k at bits [k*WORD_SIZE +: WORD_SIZE].
- wdata  input  NUM_CH*WORD_SIZE  flattened write data, same packing.
- gnt  output  NUM_CH  one-hot grant pulse.
- done  output  NUM_CH  one-hot completion pulse.
- rdata  output  WORD_SIZE  read result, valid while done is high.
- mem_readM  output  1  memory read strobe.
- mem_writeM  output  1  memory write strobe.
- mem_address  output  WORD_SIZE  memory address.
- mem_wdata  output  WORD_SIZE  memory write data.
- mem_rdata  input  WORD_SIZE  memory read data, valid in the last access cycle.
- busy  output  1  high in ACCESS and DONE.
- access_count  output  WORD_SIZE  completed-access counter.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: every output is 0. State = IDLE. Round-robin pointer last = NUM_CH-1, so channel 0 wins first. Cycle counter = 0.
- FSM states:
  - IDLE: if any req bit is high at edge t, select a winner and latch its channel, address, we and wdata. Go to ACCESS.
  - ACCESS: lasts exactly MEM_LATENCY cycles (t+1 .. t+MEM_LATENCY).
  - DONE: lasts exactly one cycle (t+MEM_LATENCY+1), then back to IDLE.
- gnt[winner]: high only in cycle t+1.
- During ACCESS:
  - mem_address and mem_wdata hold the latched values, stable for all ACCESS cycles.
  - For a read, mem_readM is high for all ACCESS cycles. For a write, mem_writeM is high for all ACCESS cycles. The two are never high together.
  - The counter runs 0..MEM_LATENCY-1. At the final ACCESS edge, mem_rdata is captured into rdata (reads only).
- During DONE:
  - done[winner] is high. Both strobes are low.
  - rdata holds the captured value. On a write, rdata keeps its previous value.
  - access_count increments by 1 at the edge entering DONE and wraps at 2^WORD_SIZE.
- Throughput: no arbitration in DONE. Earliest next grant is cycle t+MEM_LATENCY+2, so one access takes MEM_LATENCY+2 cycles.
- Requester contract: hold req and its operands until done, and drop req by the edge after done. Otherwise a new access is arbitrated.
- Arbitration:
  - Round-robin: search from last+1 upward modulo NUM_CH. The first set req wins, and last is updated to the winner at grant.
  - Fixed priority: the lowest-index set req wins, and last is unused.
  - Only req bits sampled in IDLE count. Requests that arrive during ACCESS or DONE wait.
- req deasserted mid-access: ignored. The access completes and done still pulses.
- we/addr/wdata changed mid-access: no effect, because they are latched at grant.
- reset during ACCESS or DONE: the access is aborted. Strobes, gnt and done are 0 from the next cycle. No done pulse. access_count = 0.
- MEM_LATENCY=1: a single strobe cycle (t+1), done at t+2.
- Invariants: gnt and done are each one-hot or zero. gnt and done are never high in the same cycle.

Test Plan:
- Single read: NUM_CH=2, MEM_LATENCY=2. req=01, addr0=0x0040, mem_rdata=0xBEEF during ACCESS -> gnt=01 at t+1; mem_readM high t+1..t+2 with mem_address=0x0040; done=01 and rdata=0xBEEF at t+3; access_count=1.
- Write: req=10, we=10, addr1=0x0100, wdata1=0x1234 -> mem_writeM high 2 cycles with mem_wdata=0x1234; mem_readM never high; done=10; rdata unchanged.
- Round-robin fairness: both channels request continuously, each dropping and reasserting req right after its done -> grants alternate 0,1,0,1. With RR_MODE=0, channel 0 wins every time both request.
- Latency sweep: MEM_LATENCY = 1, 3, 5 -> strobe width equals MEM_LATENCY; done at t+MEM_LATENCY+1; next grant no earlier than t+MEM_LATENCY+2.
- Reset mid-access: assert reset in the second ACCESS cycle -> next cycle all outputs 0; no done; access_count=0; the following req=01 is granted normally with channel 0 first.
- Counter wrap and NUM_CH=4: preload 0xFFFF accesses via forced count or a long run -> access_count wraps to 0x0000. With NUM_CH=4 and req=1111, grants go in order 0,1,2,3.
